// File: rtl/hps_slc_dispatch.sv
// hps_slc_dispatch
//   Queues sector-logic candidates for the downstream HPS. Each load presents
//   up to N_CAND candidates under a valid mask. The valid ones are compacted
//   into a DEPTH-entry FIFO in the same cycle, in ascending index order. If
//   the FIFO runs out of room, the highest-index candidates are the ones
//   discarded.
//
// Optional feature (macro HPS_SLC_DISPATCH_MON_EN):
//   defined   -> drop counter and overflow pulse are built
//   undefined -> o_drop_cnt / o_overflow tied to 0; FIFO and o_count unchanged
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous reset, active low
//   i_flush      clear all queued candidates at the next edge (wins over load/pop)
//   i_load       qualifies i_slc / i_slc_valid for one cycle
//   i_slc_valid  per-candidate valid mask, bit k qualifies candidate k
//   i_slc        packed candidates, candidate 0 in the MSBs
//   o_slc        FIFO head candidate (0 when empty)
//   o_valid      o_slc holds a queued candidate
//   i_ready      downstream accepts o_slc when o_valid=1
//   o_count      current FIFO occupancy
//   o_drop_cnt   saturating count of candidates discarded for lack of space
//   o_overflow   one-cycle pulse after a load that discarded a candidate
module hps_slc_dispatch #(
    parameter int  SLC_W  = 128,
    parameter int  N_CAND = 3,
    parameter int  DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_load,
    input  logic [N_CAND-1:0]       i_slc_valid,
    input  logic [N_CAND*SLC_W-1:0] i_slc,
    output logic [SLC_W-1:0]        o_slc,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [CNT_W-1:0]        o_count,
    output logic [15:0]             o_drop_cnt,
    output logic                    o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [SLC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [N_CAND-1:0] we_p0;
    logic [PTR_W-1:0]  widx_p0 [N_CAND];
    logic [CNT_W-1:0]  push_cnt_p0;
    logic [CNT_W-1:0]  free_cnt_p0;
    logic              pop_p0;
`ifdef HPS_SLC_DISPATCH_MON_EN
    logic [3:0]        drop_num_p0;
`endif

    assign o_valid = (count != '0);
    assign o_count = count;
    // Head is masked when empty so a stale memory word is never presented.
    assign o_slc   = o_valid ? mem[rd_ptr] : '0;
    assign pop_p0  = o_valid & i_ready;

    // ---- stage p0: compact valid candidates into consecutive free slots ----
    // Free space is taken from the occupancy at the start of the cycle; a
    // same-cycle pop does not make room for this load.
    always_comb begin
        we_p0       = '0;
        push_cnt_p0 = '0;
        free_cnt_p0 = CNT_W'(DEPTH) - count;
`ifdef HPS_SLC_DISPATCH_MON_EN
        drop_num_p0 = '0;
`endif
        for (int k = 0; k < N_CAND; k++) begin
            widx_p0[k] = '0;
            if (i_load && i_slc_valid[k]) begin
                if (push_cnt_p0 < free_cnt_p0) begin
                    we_p0[k]    = 1'b1;
                    widx_p0[k]  = wr_ptr + push_cnt_p0[PTR_W-1:0];
                    push_cnt_p0 = push_cnt_p0 + CNT_W'(1);
                end
`ifdef HPS_SLC_DISPATCH_MON_EN
                else begin
                    drop_num_p0 = drop_num_p0 + 4'd1;
                end
`endif
            end
        end
    end

    // ---- stage p1: FIFO control state ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt_p0[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop_p0);
            count  <= count + push_cnt_p0 - CNT_W'(pop_p0);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CAND; k++) begin
            if (we_p0[k] && !i_flush) begin
                mem[widx_p0[k]] <= i_slc[(N_CAND-1-k)*SLC_W +: SLC_W];
            end
        end
    end

`ifdef HPS_SLC_DISPATCH_MON_EN
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // ---- stage p1: drop monitor ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_drop_cnt <= '0;
            o_overflow <= 1'b0;
        end else if (i_flush) begin
            o_overflow <= 1'b0;
        end else begin
            o_drop_cnt <= sat_add16(o_drop_cnt, drop_num_p0);
            o_overflow <= (drop_num_p0 != 4'd0);
        end
    end
`else
    assign o_drop_cnt = '0;
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_hps_slc_dispatch.sv
module tb_hps_slc_dispatch;

    localparam int SLC_W  = 128;
    localparam int N_CAND = 3;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
`ifdef HPS_SLC_DISPATCH_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic                    clk;
    logic                    rst;
    logic                    i_flush;
    logic                    i_load;
    logic [N_CAND-1:0]       i_slc_valid;
    logic [N_CAND*SLC_W-1:0] i_slc;
    logic [SLC_W-1:0]        o_slc;
    logic                    o_valid;
    logic                    i_ready;
    logic [CNT_W-1:0]        o_count;
    logic [15:0]             o_drop_cnt;
    logic                    o_overflow;

    int          passed = 0;
    int          total  = 0;
    logic [15:0] exp_drop = 16'd0;

    hps_slc_dispatch #(.SLC_W(SLC_W), .N_CAND(N_CAND), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_load(i_load),
        .i_slc_valid(i_slc_valid), .i_slc(i_slc), .o_slc(o_slc),
        .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
        .o_drop_cnt(o_drop_cnt), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load3(input logic [2:0] m, input logic [SLC_W-1:0] a,
                         input logic [SLC_W-1:0] b, input logic [SLC_W-1:0] c);
        i_load      = 1'b1;
        i_slc_valid = m;
        i_slc       = {a, b, c};
    endtask

    task automatic idle();
        i_load      = 1'b0;
        i_slc_valid = '0;
        i_flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_ready = 1'b0; i_slc = '0; idle();
        tick(); tick();
        total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", o_valid); else passed++;
        total++; if (o_count !== 4'd0) $display("FAIL rst_count got %0d want 0", o_count); else passed++;
        total++; if (o_slc !== '0) $display("FAIL rst_slc got %h want 0", o_slc); else passed++;
        total++; if (o_drop_cnt !== 16'd0) $display("FAIL rst_drop got %0d want 0", o_drop_cnt); else passed++;
        total++; if (o_overflow !== 1'b0) $display("FAIL rst_ovf got %0b want 0", o_overflow); else passed++;
        rst = 1'b1;
    endtask

    task automatic test_compact();
        i_ready = 1'b1;
        load3(3'b000, 128'hA, 128'hB, 128'hC);
        tick();
        total++; if (o_count !== 4'd0 || o_valid !== 1'b0) $display("FAIL empty_load got cnt=%0d vld=%0b want 0/0", o_count, o_valid); else passed++;
        load3(3'b101, 128'hA, 128'hB, 128'hC);
        tick(); idle();
        total++; if (o_valid !== 1'b1 || o_slc !== 128'hA) $display("FAIL compact_first got vld=%0b slc=%h want 1/A", o_valid, o_slc); else passed++;
        total++; if (o_count !== 4'd2) $display("FAIL compact_cnt0 got %0d want 2", o_count); else passed++;
        tick();
        total++; if (o_valid !== 1'b1 || o_slc !== 128'hC) $display("FAIL compact_second got vld=%0b slc=%h want 1/C", o_valid, o_slc); else passed++;
        total++; if (o_count !== 4'd1) $display("FAIL compact_cnt1 got %0d want 1", o_count); else passed++;
        tick();
        total++; if (o_valid !== 1'b0 || o_count !== 4'd0) $display("FAIL compact_empty got vld=%0b cnt=%0d want 0/0", o_valid, o_count); else passed++;
    endtask

    task automatic test_overflow();
        i_ready = 1'b0;
        load3(3'b111, 128'hD0, 128'hD1, 128'hD2); tick();
        total++; if (o_overflow !== 1'b0) $display("FAIL ovf_l1 got %0b want 0", o_overflow); else passed++;
        load3(3'b111, 128'hD3, 128'hD4, 128'hD5); tick();
        total++; if (o_overflow !== 1'b0) $display("FAIL ovf_l2 got %0b want 0", o_overflow); else passed++;
        load3(3'b111, 128'hD6, 128'hD7, 128'hD8); tick(); idle();
        exp_drop = exp_drop + 16'd1;
        total++; if (o_count !== 4'd8) $display("FAIL ovf_cnt got %0d want 8", o_count); else passed++;
        total++; if (o_overflow !== MON) $display("FAIL ovf_pulse got %0b want %0b", o_overflow, MON); else passed++;
        total++; if (o_drop_cnt !== (MON ? exp_drop : 16'd0)) $display("FAIL ovf_drop got %0d want %0d", o_drop_cnt, MON ? exp_drop : 16'd0); else passed++;
        tick();
        total++; if (o_overflow !== 1'b0) $display("FAIL ovf_pulse_end got %0b want 0", o_overflow); else passed++;
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (o_valid !== 1'b1 || o_slc !== SLC_W'(8'hD0 + i)) $display("FAIL ovf_drain%0d got vld=%0b slc=%h want 1/%h", i, o_valid, o_slc, 8'hD0 + i); else passed++;
            tick();
        end
        total++; if (o_valid !== 1'b0 || o_count !== 4'd0) $display("FAIL ovf_drained got vld=%0b cnt=%0d want 0/0", o_valid, o_count); else passed++;
    endtask

    task automatic test_simul_push_pop();
        i_ready = 1'b0;
        load3(3'b111, 128'h1, 128'h2, 128'h3); tick();
        load3(3'b111, 128'h4, 128'h5, 128'h6); tick();
        load3(3'b001, 128'h7, 128'h0, 128'h0); tick();
        total++; if (o_count !== 4'd7) $display("FAIL sim_pre got %0d want 7", o_count); else passed++;
        i_ready = 1'b1;
        load3(3'b011, 128'h8, 128'h9, 128'hF); tick(); idle(); i_ready = 1'b0;
        exp_drop = exp_drop + 16'd1;
        total++; if (o_count !== 4'd7) $display("FAIL sim_cnt got %0d want 7", o_count); else passed++;
        total++; if (o_slc !== 128'h2) $display("FAIL sim_head got %h want 2", o_slc); else passed++;
        total++; if (o_overflow !== MON) $display("FAIL sim_ovf got %0b want %0b", o_overflow, MON); else passed++;
        total++; if (o_drop_cnt !== (MON ? exp_drop : 16'd0)) $display("FAIL sim_drop got %0d want %0d", o_drop_cnt, MON ? exp_drop : 16'd0); else passed++;
    endtask

    task automatic test_flush();
        i_flush = 1'b1; tick(); idle();
        total++; if (o_count !== 4'd0) $display("FAIL flush0_cnt got %0d want 0", o_count); else passed++;
        load3(3'b111, 128'h11, 128'h12, 128'h13); tick();
        load3(3'b011, 128'h14, 128'h15, 128'h16); tick();
        total++; if (o_count !== 4'd5) $display("FAIL flush_pre got %0d want 5", o_count); else passed++;
        i_ready = 1'b1; i_flush = 1'b1;
        load3(3'b111, 128'h17, 128'h18, 128'h19); tick(); idle();
        total++; if (o_count !== 4'd0 || o_valid !== 1'b0) $display("FAIL flush_cnt got cnt=%0d vld=%0b want 0/0", o_count, o_valid); else passed++;
        total++; if (o_drop_cnt !== (MON ? exp_drop : 16'd0)) $display("FAIL flush_drop got %0d want %0d", o_drop_cnt, MON ? exp_drop : 16'd0); else passed++;
        total++; if (o_overflow !== 1'b0) $display("FAIL flush_ovf got %0b want 0", o_overflow); else passed++;
        tick();
        total++; if (o_count !== 4'd0 || o_slc !== '0) $display("FAIL flush_hold got cnt=%0d slc=%h want 0/0", o_count, o_slc); else passed++;
    endtask

    task automatic test_wrap();
        logic [SLC_W-1:0] q[$];
        logic [SLC_W-1:0] seq;
        int free, np, nd, last_nd;
        logic rdy;
        seq = 128'h1000; last_nd = 0;
        for (int c = 0; c < 30; c++) begin
            total++; if (o_valid !== (q.size() != 0)) $display("FAIL wrap_vld c%0d got %0b want %0b", c, o_valid, q.size() != 0); else passed++;
            if (q.size() != 0) begin
                total++; if (o_slc !== q[0]) $display("FAIL wrap_slc c%0d got %h want %h", c, o_slc, q[0]); else passed++;
            end
            total++; if (o_count !== CNT_W'(q.size())) $display("FAIL wrap_cnt c%0d got %0d want %0d", c, o_count, q.size()); else passed++;
            total++; if (o_overflow !== (MON && last_nd != 0)) $display("FAIL wrap_ovf c%0d got %0b want %0b", c, o_overflow, MON && last_nd != 0); else passed++;
            rdy = (c < 20) ? c[0] : 1'b1;
            i_ready = rdy;
            np = 0; nd = 0;
            if (c < 20) begin
                load3(3'b111, seq, seq + 1, seq + 2);
                free = DEPTH - q.size();
                for (int k = 0; k < 3; k++) begin
                    if (np < free) begin q.push_back(seq + SLC_W'(k)); np++; end
                    else nd++;
                end
                seq = seq + 3;
            end else begin
                idle();
            end
            if (rdy && (q.size() - np) != 0) void'(q.pop_front());
            exp_drop = exp_drop + 16'(nd);
            last_nd = nd;
            tick();
        end
        idle();
        total++; if (o_count !== 4'd0 || q.size() != 0) $display("FAIL wrap_end got cnt=%0d model=%0d want 0", o_count, q.size()); else passed++;
        total++; if (o_drop_cnt !== (MON ? exp_drop : 16'd0)) $display("FAIL wrap_drop got %0d want %0d", o_drop_cnt, MON ? exp_drop : 16'd0); else passed++;
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        load3(3'b111, 128'h21, 128'h22, 128'h23); tick();
        load3(3'b001, 128'h24, 128'h0, 128'h0); tick(); idle();
        total++; if (o_count !== 4'd4) $display("FAIL rmid_pre got %0d want 4", o_count); else passed++;
        #2 rst = 1'b0;
        #1;
        exp_drop = 16'd0;
        total++; if (o_count !== 4'd0 || o_valid !== 1'b0) $display("FAIL rmid_async got cnt=%0d vld=%0b want 0/0", o_count, o_valid); else passed++;
        total++; if (o_slc !== '0 || o_drop_cnt !== 16'd0 || o_overflow !== 1'b0) $display("FAIL rmid_outs got slc=%h drop=%0d ovf=%0b want 0", o_slc, o_drop_cnt, o_overflow); else passed++;
        tick();
        rst = 1'b1; i_ready = 1'b1;
        load3(3'b001, 128'h5A, 128'h5B, 128'h5C); tick(); idle();
        total++; if (o_valid !== 1'b1 || o_slc !== 128'h5A || o_count !== 4'd1) $display("FAIL rmid_first got vld=%0b slc=%h cnt=%0d want 1/5a/1", o_valid, o_slc, o_count); else passed++;
        tick();
        total++; if (o_valid !== 1'b0 || o_count !== 4'd0) $display("FAIL rmid_done got vld=%0b cnt=%0d want 0/0", o_valid, o_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_compact();
        test_overflow();
        test_simul_push_pop();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hps_slc_dispatch.md
HPS_SLC_DISPATCH -- requirements
Module: hps_slc_dispatch

Interface
REQ-001 Parameter SLC_W, default 128, width of one sector-logic candidate word.
REQ-002 Parameter N_CAND, default 3, candidates presented per load, range 1..8.
REQ-003 Parameter DEPTH, default 8, FIFO entries, power of two, DEPTH >= N_CAND.
REQ-004 Derived CNT_W = clog2(DEPTH)+1.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 i_flush  in  1  TTC-derived clear of queued candidates.
REQ-008 i_load  in  1  qualifies i_slc/i_slc_valid for one cycle.
REQ-009 i_slc_valid  in  N_CAND  per-candidate valid mask; bit k qualifies candidate k.
REQ-010 i_slc  in  N_CAND*SLC_W  packed candidates, streaming order: candidate 0 in MSBs, candidate N_CAND-1 in LSBs.
REQ-011 o_slc  out  SLC_W  FIFO head candidate.
REQ-012 o_valid  out  1  o_slc holds a queued candidate.
REQ-013 i_ready  in  1  downstream HPS accepts o_slc when o_valid=1.
REQ-014 o_count  out  CNT_W  current FIFO occupancy.
REQ-015 o_drop_cnt  out  16  candidates discarded due to lack of space.
REQ-016 o_overflow  out  1  one-cycle pulse when at least one candidate is dropped.

Function
REQ-017 On i_load=1, valid candidates are written in ascending index order, compacted (invalid slots skipped), all in the same cycle.
REQ-018 Free space for a load = DEPTH - o_count at the start of the cycle; a same-cycle pop is not credited.
REQ-019 Valid candidates beyond the free space are discarded, highest indices first; o_drop_cnt increments by the number discarded, saturating at 0xFFFF.
REQ-020 o_overflow is 1 in the cycle after a load that discarded at least one candidate, otherwise 0.
REQ-021 Pop occurs when o_valid=1 and i_ready=1; i_ready while o_valid=0 has no effect.
REQ-022 Write-to-output latency is 1 cycle: a candidate written into an empty FIFO appears with o_valid=1 on the next cycle.
REQ-023 o_slc and o_valid are stable while o_valid=1 and i_ready=0.
REQ-024 Simultaneous push and pop: o_count(next) = o_count + pushed - 1.
REQ-025 Read and write pointers wrap modulo DEPTH without bubbles.
REQ-026 i_flush=1 empties the FIFO at the next edge; it overrides a same-cycle load and pop; flushed or suppressed candidates are not counted as drops.
REQ-027 o_drop_cnt is cleared only by reset, not by i_flush.
REQ-028 i_load=1 with i_slc_valid=0 leaves all state unchanged.

Reset
REQ-029 While rst=0: pointers=0, o_count=0, o_valid=0, o_slc=0, o_drop_cnt=0, o_overflow=0.
REQ-030 Reset assertion mid-transfer discards all queued candidates; no partial candidate is presented after deassertion.
REQ-031 The first load is accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro HPS_SLC_DISPATCH_MON_EN defined: o_count, o_drop_cnt and o_overflow behave as in REQ-014..020.
REQ-033 Macro HPS_SLC_DISPATCH_MON_EN undefined: o_drop_cnt and o_overflow are tied to 0, the drop counter is not built, and o_count remains functional; FIFO behaviour is unchanged.

Verification
REQ-034 Defaults; load mask 3'b101 with candidates A,B,C into an empty FIFO, i_ready=1 -> A then C on consecutive cycles, first o_valid 1 cycle after load, o_count returns to 0.
REQ-035 i_ready=0; three loads with mask 3'b111 -> o_count=8, o_drop_cnt=1, o_overflow pulses once, dropped word is candidate 2 of the third load.
REQ-036 o_count=7, load mask 3'b011 with simultaneous pop -> one written, one dropped, o_count=7.
REQ-037 FIFO holding 5 entries; i_flush=1 with a same-cycle load of 3'b111 -> o_count=0 and o_valid=0 next cycle, o_drop_cnt unchanged.
REQ-038 Run 20 loads of 3'b111 with i_ready toggling every cycle -> output order equals input order across pointer wrap, with no duplicate or missing candidates other than those counted in o_drop_cnt.
REQ-039 Assert rst=0 with 4 entries queued while i_ready=0 -> all outputs 0 asynchronously; after release, one load of 3'b001 -> single candidate output.
